// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, command bytes and frame helpers.
package ps2_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_INHIBIT,
    TX_START,
    TX_SHIFT,
    TX_ACK,
    TX_WAIT_IDLE
  } ps2_tx_state_t;

  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_SET_RATE = 8'hF3;
  localparam logic [7:0] PS2_ACK          = 8'hFA;

  localparam int PS2_FRAME_BITS = 10;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  // Bit 0 goes out first: D0..D7, parity, stop.
  function automatic logic [PS2_FRAME_BITS-1:0] build_frame(input logic [7:0] b);
    return {1'b1, odd_parity(b), b};
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake and completion status between a requester and ps2_host_tx.
interface ps2_host_tx_if;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out;
  logic       done_out;
  logic       ack_ok_out;
  logic       err_out;

  modport master (
    output data_in, valid_in,
    input  ready_out, done_out, ack_ok_out, err_out
  );

  modport slave (
    input  data_in, valid_in,
    output ready_out, done_out, ack_ok_out, err_out
  );
endinterface

// File: rtl/ps2_sync.sv
// Two-flop synchronizer for the PS/2 clock and data pins, plus a falling-edge
// pulse on the synchronized clock.
module ps2_sync (
  input  logic clk_in,
  input  logic rst_in,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  output logic clk_sync_out,
  output logic data_sync_out,
  output logic clk_fall_out
);

  logic [2:0] clk_pipe_q, clk_pipe_d;
  logic [1:0] data_pipe_q, data_pipe_d;

  always_comb begin
    clk_pipe_d  = {clk_pipe_q[1:0], ps2_clk_in};
    data_pipe_d = {data_pipe_q[0], ps2_data_in};
  end

  // Idle bus level is high, so reset to 1 to avoid a false edge after reset.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      clk_pipe_q  <= '1;
      data_pipe_q <= '1;
    end else begin
      clk_pipe_q  <= clk_pipe_d;
      data_pipe_q <= data_pipe_d;
    end
  end

  assign clk_sync_out  = clk_pipe_q[1];
  assign data_sync_out = data_pipe_q[1];
  assign clk_fall_out  = clk_pipe_q[2] & ~clk_pipe_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, device-clocked shifting of
// one command frame, acknowledge capture and per-edge timeout.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 12_000,
  parameter int SETUP_CYCLES   = 200,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic         clk_in,
  input  logic         rst_in,
  ps2_host_tx_if.slave bus,
  input  logic         ps2_clk_in,
  input  logic         ps2_data_in,
  output logic         ps2_clk_oe_out,
  output logic         ps2_data_oe_out
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES) + 1;
  localparam int SET_W = $clog2(SETUP_CYCLES) + 1;
  localparam int PH_W  = (INH_W > SET_W) ? INH_W : SET_W;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [PH_W-1:0] INH_LAST = PH_W'(INHIBIT_CYCLES - 1);
  localparam logic [PH_W-1:0] SET_LAST = PH_W'(SETUP_CYCLES - 1);
  localparam logic [PH_W-1:0] PH_MAX   = '1;
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
  localparam logic [3:0]      LAST_IDX = 4'(PS2_FRAME_BITS - 1);

  ps2_tx_state_t             state_q, state_d;
  logic [PS2_FRAME_BITS-1:0] frame_q, frame_d;
  logic [3:0]                idx_q, idx_d;
  logic [PH_W-1:0]           ph_cnt_q, ph_cnt_d, ph_inc;
  logic [TO_W-1:0]           to_cnt_q, to_cnt_d, to_inc;
  logic                      clk_oe_q, clk_oe_d;
  logic                      data_oe_q, data_oe_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;
  logic                      ack_smp_q, ack_smp_d;
  logic                      ack_ok_q, ack_ok_d;
  logic                      clk_sync, data_sync, clk_fall;
  logic                      waiting_dev;

  ps2_sync u_sync (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .ps2_clk_in    (ps2_clk_in),
    .ps2_data_in   (ps2_data_in),
    .clk_sync_out  (clk_sync),
    .data_sync_out (data_sync),
    .clk_fall_out  (clk_fall)
  );

  always_comb begin
    ph_inc = (ph_cnt_q == PH_MAX) ? ph_cnt_q : ph_cnt_q + 1'b1;
    to_inc = (to_cnt_q == TO_LIMIT) ? to_cnt_q : to_cnt_q + 1'b1;
    waiting_dev = (state_q == TX_SHIFT) || (state_q == TX_ACK) ||
                  (state_q == TX_WAIT_IDLE);
  end

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    idx_d     = idx_q;
    ph_cnt_d  = ph_cnt_q;
    to_cnt_d  = to_cnt_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    ack_smp_d = ack_smp_q;
    ack_ok_d  = ack_ok_q;

    unique case (state_q)
      TX_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (bus.valid_in) begin
          frame_d  = build_frame(bus.data_in);
          clk_oe_d = 1'b1;
          ph_cnt_d = '0;
          ack_ok_d = 1'b0;
          state_d  = TX_INHIBIT;
        end
      end
      TX_INHIBIT: begin
        if (ph_cnt_q == INH_LAST) begin
          data_oe_d = 1'b1;
          ph_cnt_d  = '0;
          state_d   = TX_START;
        end else begin
          ph_cnt_d = ph_inc;
        end
      end
      TX_START: begin
        if (ph_cnt_q == SET_LAST) begin
          clk_oe_d = 1'b0;
          idx_d    = '0;
          to_cnt_d = '0;
          state_d  = TX_SHIFT;
        end else begin
          ph_cnt_d = ph_inc;
        end
      end
      TX_SHIFT: begin
        if (clk_fall) begin
          data_oe_d = ~frame_q[idx_q];
          idx_d     = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = TX_ACK;
          end
        end
      end
      TX_ACK: begin
        if (clk_fall) begin
          ack_smp_d = ~data_sync;
          state_d   = TX_WAIT_IDLE;
        end
      end
      TX_WAIT_IDLE: begin
        // Status is published only once the device has released both lines.
        if (clk_sync && data_sync) begin
          done_d   = 1'b1;
          ack_ok_d = ack_smp_q;
          state_d  = TX_IDLE;
        end
      end
      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = TX_IDLE;
      end
    endcase

    // Every device clock edge restarts the watchdog; expiry abandons the frame.
    if (waiting_dev) begin
      if (clk_fall) begin
        to_cnt_d = '0;
      end else if (!done_d) begin
        to_cnt_d = to_inc;
        if (to_inc == TO_LIMIT) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          err_d     = 1'b1;
          state_d   = TX_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= TX_IDLE;
      frame_q   <= '0;
      idx_q     <= '0;
      ph_cnt_q  <= '0;
      to_cnt_q  <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ack_smp_q <= 1'b0;
      ack_ok_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      idx_q     <= idx_d;
      ph_cnt_q  <= ph_cnt_d;
      to_cnt_q  <= to_cnt_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      err_q     <= err_d;
      ack_smp_q <= ack_smp_d;
      ack_ok_q  <= ack_ok_d;
    end
  end

  assign bus.ready_out   = (state_q == TX_IDLE);
  assign bus.done_out    = done_q;
  assign bus.err_out     = err_q;
  assign bus.ack_ok_out  = ack_ok_q;
  assign ps2_clk_oe_out  = clk_oe_q;
  assign ps2_data_oe_out = data_oe_q;

endmodule
